// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: grants one requester,
// issues its operands to the ALU for one cycle and returns the registered result.
// Build option ALU_ARB_RR_EN: round-robin arbitration; undefined gives fixed priority (port 0 wins).

// state | meaning
// IDLE  | waiting for a request, grant shown on req_ready
// ISSUE | latched operands on alu_*, result captured at the end of this cycle
// RESP  | rsp_valid[owner] held until rsp_ready[owner]
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int PC_W          = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [OPCODE_LENGTH-1:0] req_op0,
    input  logic [OPCODE_LENGTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0]    req_a0,
    input  logic [DATA_WIDTH-1:0]    req_a1,
    input  logic [DATA_WIDTH-1:0]    req_b0,
    input  logic [DATA_WIDTH-1:0]    req_b1,
    input  logic [PC_W-1:0]          req_pc0,
    input  logic [PC_W-1:0]          req_pc1,
    output logic [DATA_WIDTH-1:0]    alu_SrcA,
    output logic [DATA_WIDTH-1:0]    alu_SrcB,
    output logic [OPCODE_LENGTH-1:0] alu_Operation,
    output logic [PC_W-1:0]          alu_Curr_Pc,
    input  logic [DATA_WIDTH-1:0]    alu_ALUResult,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_id;
    logic   owner;
    logic   xfer;

`ifdef ALU_ARB_RR_EN
    // rr_ptr names the requester favoured on the next contended cycle
    logic rr_ptr;

    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11)
            grant_id = rr_ptr;
        else if (req_valid[1])
            grant_id = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= 1'b0;
        else if (xfer)
            rr_ptr <= ~grant_id;
    end
`else
    always_comb begin
        grant_id = 1'b0;
        if (!req_valid[0] && req_valid[1])
            grant_id = 1'b1;
    end
`endif

    // Gated with reset so nothing is offered while reset is held
    always_comb begin
        req_ready = 2'b00;
        if (reset && (state == IDLE))
            req_ready = (grant_id ? 2'b10 : 2'b01) & req_valid;
    end

    assign xfer = |(req_valid & req_ready);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // alu_* double as the operand latch, so they only change on an accepted transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner         <= 1'b0;
            alu_SrcA      <= '0;
            alu_SrcB      <= '0;
            alu_Operation <= '0;
            alu_Curr_Pc   <= '0;
            rsp_valid     <= 2'b00;
            rsp_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        owner         <= grant_id;
                        alu_SrcA      <= grant_id ? req_a1  : req_a0;
                        alu_SrcB      <= grant_id ? req_b1  : req_b0;
                        alu_Operation <= grant_id ? req_op1 : req_op0;
                        alu_Curr_Pc   <= grant_id ? req_pc1 : req_pc0;
                    end
                end
                ISSUE: begin
                    rsp_data  <= alu_ALUResult;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                end
                RESP: begin
                    if (rsp_ready[owner])
                        rsp_valid <= 2'b00;
                end
                default: rsp_valid <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a reference ALU and a response scoreboard.
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [8:0]  req_pc0, req_pc1;
    logic [31:0] alu_SrcA, alu_SrcB;
    logic [3:0]  alu_Operation;
    logic [8:0]  alu_Curr_Pc;
    logic [31:0] alu_ALUResult;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .req_pc0(req_pc0), .req_pc1(req_pc1),
        .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB),
        .alu_Operation(alu_Operation), .alu_Curr_Pc(alu_Curr_Pc),
        .alu_ALUResult(alu_ALUResult),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU
    always_comb begin
        case (alu_Operation)
            4'b0000: alu_ALUResult = alu_SrcA + alu_SrcB;
            4'b0001: alu_ALUResult = alu_SrcA - alu_SrcB;
            4'b0010: alu_ALUResult = alu_SrcA & alu_SrcB;
            4'b0011: alu_ALUResult = alu_SrcA | alu_SrcB;
            4'b1111: alu_ALUResult = {23'd0, alu_Curr_Pc} + 32'd4;
            default: alu_ALUResult = alu_SrcA ^ alu_SrcB;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a response completes where rsp_valid meets rsp_ready
    always @(negedge clk) begin
        if (reset === 1'b1 && (rsp_valid & rsp_ready) != 2'b00) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got valid=%b data=%0h, expected no response", rsp_valid, rsp_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_owner", {30'd0, rsp_valid}, e.owner ? 32'd2 : 32'd1);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    // Presents one request, waits for its grant and leaves the DUT in ISSUE (posedge+1)
    task automatic send(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [8:0] pc,
                        input logic [31:0] exp, input bit push);
        bit got;
        got = 0;
        if (id == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_pc0 = pc; req_valid[0] = 1'b1;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_pc1 = pc; req_valid[1] = 1'b1;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got no req_ready for %0d, expected grant", id);
        end
        if (push) sbq.push_back('{owner: (id == 1), data: exp});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_op", {28'd0, alu_Operation}, {28'd0, op});
        chk("issue_srca", alu_SrcA, a);
        chk("issue_pc", {23'd0, alu_Curr_Pc}, {23'd0, pc});
        chk("issue_no_rsp", {30'd0, rsp_valid}, 32'd0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%b, expected 0", busy);
        end
        @(posedge clk); #1;
    endtask

    logic exp_grant [4];
    int   grants;

    initial begin
        reset = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_op0 = 4'd0; req_op1 = 4'd0;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        req_pc0 = 9'd0; req_pc1 = 9'd0;

        // Reset values, with both requests already raised
        #13;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_srca", alu_SrcA, 32'd0);
        chk("rst_alu_pc", {23'd0, alu_Curr_Pc}, 32'd0);
        req_valid = 2'b00;
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Req0 add: 5 + 7 = 12
        send(0, 4'b0000, 32'd5, 32'd7, 9'd0, 32'd12, 1);
        @(posedge clk); #1;
        chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("t1_busy_done", {31'd0, busy}, 32'd0);

        // Req1 pc op: 16 + 4 = 20
        send(1, 4'b1111, 32'd0, 32'd0, 9'd16, 32'd20, 1);
        @(posedge clk); #1;
        chk("t2_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        wait_idle();

        // Both valid continuously; pointer favours 0 here
`ifdef ALU_ARB_RR_EN
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req_op0 = 4'b0000; req_a0 = 32'd1;    req_b0 = 32'd1;    req_pc0 = 9'd0;
        req_op1 = 4'b0010; req_a1 = 32'hF0;   req_b1 = 32'h3C;   req_pc1 = 9'd0;
        req_valid = 2'b11;
        grants = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk("arb_onehot", {31'd0, (req_ready == 2'b01 || req_ready == 2'b10)}, 32'd1);
                chk("arb_grant", {31'd0, req_ready[1]}, {31'd0, exp_grant[grants]});
                sbq.push_back('{owner: req_ready[1], data: req_ready[1] ? 32'h30 : 32'd2});
                grants++;
            end
        end
        chk("arb_grant_count", grants, 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Req0 sub 3 - 5 with a stalled consumer
        rsp_ready = 2'b00;
        send(0, 4'b0001, 32'd3, 32'd5, 9'd0, 32'hFFFFFFFE, 1);
        @(posedge clk); #1;
        req_op1 = 4'b0011; req_a1 = 32'h0F; req_b1 = 32'hF0;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_data", rsp_data, 32'hFFFFFFFE);
            chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("stall_done_busy", {31'd0, busy}, 32'd0);
        chk("stall_done_valid", {30'd0, rsp_valid}, 32'd0);

        // Reset during ISSUE aborts the op
        rsp_ready = 2'b11;
        send(0, 4'b0000, 32'd40, 32'd2, 9'd0, 32'd42, 0);
        #2 reset = 1'b0;
        #1;
        chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_alu_srca", alu_SrcA, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        send(1, 4'b1111, 32'd0, 32'd0, 9'd100, 32'd104, 1);
        wait_idle();

        // rsp_ready on the wrong bit must not complete req0
        rsp_ready = 2'b10;
        send(0, 4'b0000, 32'd100, 32'd23, 9'd0, 32'd123, 1);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("wrong_owner_valid", {30'd0, rsp_valid}, 32'd1);
            chk("wrong_owner_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        wait_idle();

        repeat (3) @(posedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
